// File: rtl/bcd_scan_decoder_pkg.sv
// Shared constants, types and helpers for the multiplexed BCD display decoder.
package bcd_scan_pkg;

  localparam int BCD_W   = 4;
  localparam int DEC_W   = 10;
  localparam int BCD_MAX = 9;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [DEC_W-1:0] dec_t;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bcd_scan_decoder_if.sv
// Bus between the datapath and the scanned BCD display decoder.
// load is a single-cycle strobe with no back-pressure: the decoder accepts
// bcd_in on every cycle load is high (outside reset) and never stalls the source.
interface bcd_scan_decoder_if #(
  parameter int DIGITS = 4
);
  import bcd_scan_pkg::*;

  logic [BCD_W*DIGITS-1:0] bcd_in;
  logic                    load;
  logic [DIGITS-1:0]       dig_sel;
  dec_t                    dec_out;
  logic                    err;
  logic                    frame_start;
  logic                    pending_dbg;

  modport master (
    output bcd_in, load,
    input  dig_sel, dec_out, err, frame_start, pending_dbg
  );

  modport slave (
    input  bcd_in, load,
    output dig_sel, dec_out, err, frame_start, pending_dbg
  );

endinterface

// File: rtl/bcd_scan_decoder_dec1.sv
// Single-digit BCD to one-hot decimal decoder; codes 10-15 decode to zero
// and raise the invalid flag.
module bcd_dec1
  import bcd_scan_pkg::*;
(
  input  bcd_t digit_i,
  output dec_t dec_o,
  output logic invalid_o
);

  // Pure lookup: one-hot for 0-9, all zeros plus flag otherwise.
  always_comb begin
    dec_o     = '0;
    invalid_o = 1'b0;
    if (int'(digit_i) <= BCD_MAX) begin
      dec_o[digit_i] = 1'b1;
    end else begin
      invalid_o = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_scan_decoder.sv
// Time-multiplexed multi-digit BCD display decoder with tear-free double
// buffering, invalid-code flagging and a frame-start marker.
// Optional build macro: BCD_BLANK_EN enables leading-zero blanking.
module bcd_scan_decoder
  import bcd_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_scan_decoder_if.slave   bus
);

  localparam int CNT_W  = cnt_w(SCAN_DIV);
  localparam int IDX_W  = cnt_w(DIGITS);
  localparam int DATA_W = BCD_W * DIGITS;

  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic              pending_q, pending_d;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
  dec_t              dec_q, dec_d;
  logic              err_q, err_d;
  logic              fs_q, fs_d;

  logic              tick;
  logic              boundary;
  bcd_t              cur_digit;
  dec_t              raw_dec;
  logic              raw_inv;
  logic              blank;

  assign tick     = (div_cnt_q == CNT_W'(SCAN_DIV - 1));
  assign boundary = tick && (idx_q == IDX_W'(DIGITS - 1));

  // Prescaler and digit index advance; index wraps at the last digit.
  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: active only changes on a frame boundary; a load landing
  // on the boundary bypasses the shadow so it is shown immediately.
  always_comb begin
    shadow_d  = bus.load ? bus.bcd_in : shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary) begin
      if (bus.load) begin
        active_d = bus.bcd_in;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
  end

  // Select the digit that becomes visible after this tick, from the
  // post-transfer active value.
  always_comb begin
    cur_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        cur_digit = active_d[k*BCD_W +: BCD_W];
      end
    end
  end

  bcd_dec1 u_dec1 (
    .digit_i   (cur_digit),
    .dec_o     (raw_dec),
    .invalid_o (raw_inv)
  );

`ifdef BCD_BLANK_EN
  // Leading-zero blanking: digit k>0 is blank when it and every digit above
  // it are zero. Digit 0 is never blanked.
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run = run & (active_d[k*BCD_W +: BCD_W] == '0);
      if (idx_d == IDX_W'(k)) begin
        blank = run;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Output next-state: update on tick, hold otherwise; frame_start is a pulse.
  always_comb begin
    dig_sel_d = dig_sel_q;
    dec_d     = dec_q;
    err_d     = err_q;
    fs_d      = 1'b0;
    if (tick) begin
      for (int k = 0; k < DIGITS; k++) begin
        dig_sel_d[k] = (idx_d == IDX_W'(k));
      end
      dec_d = blank ? '0 : raw_dec;
      err_d = blank ? 1'b0 : raw_inv;
      fs_d  = (idx_d == '0);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= IDX_W'(DIGITS - 1);
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      dig_sel_q <= '0;
      dec_q     <= '0;
      err_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      dig_sel_q <= dig_sel_d;
      dec_q     <= dec_d;
      err_q     <= err_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.dig_sel     = dig_sel_q;
  assign bus.dec_out     = dec_q;
  assign bus.err         = err_q;
  assign bus.frame_start = fs_q;
  assign bus.pending_dbg = pending_q;

endmodule
